sprite_layer_renderer: RTL and testbench

- Parametrised successor to the full-screen single-sprite renderer.
- Draws one positioned, integer-scaled, multi-frame animated sprite over a background pixel stream, with a transparent colour index.
- Sits between the VGA timing generator (DrawX/DrawY/blank) and the colour mapper.
- Sprite ROM and palette are external, so one block serves any sprite.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_addr_gen.sv | 72 +++++++
 rtl/sprite_layer_renderer.sv | 182 ++++++++++++++++++
 tb/tb_sprite_layer_renderer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared screen constants and pixel types for the sprite layer renderer.
// The mirror option is controlled by the SPRITE_FLIP_EN macro in the other files.
package sprite_pkg;

    localparam int H_VIS   = 640;
    localparam int V_VIS   = 480;
    localparam int LATENCY = 3;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Window test, integer down-scaling, optional mirror and registered ROM address.
// Build with SPRITE_FLIP_EN defined to add the horizontal mirror input.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 11,
    parameter int SPR_H       = 22,
    parameter int SCALE_SHIFT = 2,
    parameter int FI_W        = 2,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  coord_t            i_draw_x,
    input  coord_t            i_draw_y,
    input  coord_t            i_act_x,
    input  coord_t            i_act_y,
    input  logic [FI_W-1:0]   i_frame_idx,
`ifdef SPRITE_FLIP_EN
    input  logic              i_flip,
`endif
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_in_win
);

    localparam logic [10:0]       WIN_W    = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0]       WIN_H    = 11'(SPR_H << SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPR_W);

    logic [10:0]       w_lx;
    logic [10:0]       w_ly;
    logic [10:0]       w_tx;
    logic [10:0]       w_ty;
    logic [10:0]       w_tx_eff;
    logic              w_in_x;
    logic              w_in_y;
    logic              w_in_win;
    logic [ADDR_W-1:0] w_addr;

    // 11-bit offsets; the >= guard keeps a negative offset from wrapping into the window.
    assign w_lx = {1'b0, i_draw_x} - {1'b0, i_act_x};
    assign w_ly = {1'b0, i_draw_y} - {1'b0, i_act_y};

    assign w_in_x   = (i_draw_x >= i_act_x) && (w_lx < WIN_W) && (i_draw_x < 10'(H_VIS));
    assign w_in_y   = (i_draw_y >= i_act_y) && (w_ly < WIN_H) && (i_draw_y < 10'(V_VIS));
    assign w_in_win = w_in_x && w_in_y;

    assign w_tx = w_lx >> SCALE_SHIFT;
    assign w_ty = w_ly >> SCALE_SHIFT;

`ifdef SPRITE_FLIP_EN
    assign w_tx_eff = i_flip ? (11'(SPR_W - 1) - w_tx) : w_tx;
`else
    assign w_tx_eff = w_tx;
`endif

    assign w_addr = ADDR_W'(i_frame_idx) * FRAME_SZ
                  + ADDR_W'(w_ty) * ROW_SZ
                  + ADDR_W'(w_tx_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            o_rom_addr <= '0;
            o_in_win   <= 1'b0;
        end else begin
            o_in_win   <= w_in_win;
            o_rom_addr <= w_in_win ? w_addr : '0;
        end
    end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Positioned, scaled, animated sprite composited over a background pixel stream.
// Define SPRITE_FLIP_EN to add the double-buffered flip_x mirror control.
module sprite_layer_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W           = 11,
    parameter int SPR_H           = 22,
    parameter int SCALE_SHIFT     = 2,
    parameter int N_FRAMES        = 4,
    parameter int ANIM_DIV        = 8,
    parameter int IDX_W           = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int ADDR_W          = $clog2(SPR_W * SPR_H * N_FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  logic              blank,
    input  coord_t            pos_x,
    input  coord_t            pos_y,
    input  logic              pos_wr,
`ifdef SPRITE_FLIP_EN
    input  logic              flip_x,
`endif
    input  logic              anim_en,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit
);

    localparam int FI_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

    logic            w_frame_start;
    logic            w_in_win_d1;
    logic            w_opaque;

    coord_t          r_act_x;
    coord_t          r_act_y;
    coord_t          r_shd_x;
    coord_t          r_shd_y;
    logic            r_pending;
    logic [7:0]      r_anim_cnt;
    logic [FI_W-1:0] r_frame_idx;
    logic            r_blank_d1;
    logic            r_blank_d2;
    logic            r_in_win_d2;
    rgb4_t           r_bg_d1;
    rgb4_t           r_bg_d2;
    rgb4_t           r_out;
    logic            r_hit;

    assign w_frame_start = (DrawX == '0) && (DrawY == '0);

`ifdef SPRITE_FLIP_EN
    logic r_shd_flip;
    logic r_act_flip;
`endif

    // Shadow/active position; a write landing on frame start goes to shadow after the swap.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_act_x   <= '0;
            r_act_y   <= '0;
            r_shd_x   <= '0;
            r_shd_y   <= '0;
            r_pending <= 1'b0;
`ifdef SPRITE_FLIP_EN
            r_shd_flip <= 1'b0;
            r_act_flip <= 1'b0;
`endif
        end else begin
            if (w_frame_start && r_pending) begin
                r_act_x   <= r_shd_x;
                r_act_y   <= r_shd_y;
                r_pending <= 1'b0;
`ifdef SPRITE_FLIP_EN
                r_act_flip <= r_shd_flip;
`endif
            end
            if (pos_wr) begin
                r_shd_x   <= pos_x;
                r_shd_y   <= pos_y;
                r_pending <= 1'b1;
`ifdef SPRITE_FLIP_EN
                r_shd_flip <= flip_x;
`endif
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_anim_cnt  <= '0;
            r_frame_idx <= '0;
        end else if (w_frame_start && anim_en) begin
            if (r_anim_cnt == 8'(ANIM_DIV - 1)) begin
                r_anim_cnt <= '0;
                if (r_frame_idx == FI_W'(N_FRAMES - 1)) begin
                    r_frame_idx <= '0;
                end else begin
                    r_frame_idx <= r_frame_idx + 1'b1;
                end
            end else begin
                r_anim_cnt <= r_anim_cnt + 8'd1;
            end
        end
    end

    sprite_addr_gen #(
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H),
        .SCALE_SHIFT (SCALE_SHIFT),
        .FI_W        (FI_W),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .clk         (vga_clk),
        .reset       (reset),
        .i_draw_x    (DrawX),
        .i_draw_y    (DrawY),
        .i_act_x     (r_act_x),
        .i_act_y     (r_act_y),
        .i_frame_idx (r_frame_idx),
`ifdef SPRITE_FLIP_EN
        .i_flip      (r_act_flip),
`endif
        .o_rom_addr  (rom_addr),
        .o_in_win    (w_in_win_d1)
    );

    // Side-band delays so blank/background line up with rom_q two cycles later.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_blank_d1  <= 1'b0;
            r_blank_d2  <= 1'b0;
            r_in_win_d2 <= 1'b0;
            r_bg_d1     <= '0;
            r_bg_d2     <= '0;
        end else begin
            r_blank_d1  <= blank;
            r_blank_d2  <= r_blank_d1;
            r_in_win_d2 <= w_in_win_d1;
            r_bg_d1     <= '{r: bg_red, g: bg_green, b: bg_blue};
            r_bg_d2     <= r_bg_d1;
        end
    end

    assign pal_index = rom_q;
    assign w_opaque  = r_in_win_d2 && (rom_q != IDX_W'(TRANSPARENT_IDX));

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_out <= '0;
            r_hit <= 1'b0;
        end else if (!r_blank_d2) begin
            r_out <= '0;
            r_hit <= 1'b0;
        end else if (w_opaque) begin
            r_out <= '{r: pal_red, g: pal_green, b: pal_blue};
            r_hit <= 1'b1;
        end else begin
            r_out <= r_bg_d2;
            r_hit <= 1'b0;
        end
    end

    assign red        = r_out.r;
    assign green      = r_out.g;
    assign blue       = r_out.b;
    assign sprite_hit = r_hit;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer: table-driven pixel probes plus timing sequences.
// The mirror checks are compiled only when SPRITE_FLIP_EN is defined.
module tb_sprite_layer_renderer;
    import sprite_pkg::*;

    localparam int SPR_W    = 11;
    localparam int SPR_H    = 22;
    localparam int N_FRAMES = 4;
    localparam int IDX_W    = 4;
    localparam int ADDR_W   = 10;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic              vga_clk = 1'b0;
    logic              reset;
    coord_t            DrawX, DrawY, pos_x, pos_y;
    logic              blank, pos_wr, anim_en;
    logic [3:0]        bg_red, bg_green, bg_blue;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q, pal_index;
    logic [3:0]        pal_red, pal_green, pal_blue;
    logic [3:0]        red, green, blue;
    logic              sprite_hit;
`ifdef SPRITE_FLIP_EN
    logic              flip_x;
`endif

    logic [IDX_W-1:0]  rom_mem [0:(1<<ADDR_W)-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_layer_renderer dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_wr     (pos_wr),
`ifdef SPRITE_FLIP_EN
        .flip_x     (flip_x),
`endif
        .anim_en    (anim_en),
        .bg_red     (bg_red),
        .bg_green   (bg_green),
        .bg_blue    (bg_blue),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .sprite_hit (sprite_hit)
    );

    // External ROM (1-cycle synchronous) and combinational palette models.
    always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];
    assign pal_red   = pal_index;
    assign pal_green = ~pal_index;
    assign pal_blue  = pal_index ^ 4'hA;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic [11:0] rgb;
        logic        hit;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int x, input int y, input logic b,
                                input logic [11:0] rgb, input logic hit);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.b = b; v.rgb = rgb; v.hit = hit;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Background is derived from the coordinates so it stays aligned with DrawX/DrawY.
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic b);
        DrawX = x; DrawY = y; blank = b;
        bg_red = x[3:0]; bg_green = y[3:0]; bg_blue = 4'h9;
    endtask

    task automatic idle();
        drive(10'd700, 10'd500, 1'b0);
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic b,
                         output logic [12:0] got);
        @(negedge vga_clk); drive(x, y, b);
        @(negedge vga_clk); idle();
        @(negedge vga_clk);
        @(negedge vga_clk);
        got = {sprite_hit, red, green, blue};
    endtask

    task automatic run_vecs(input string tag);
        logic [12:0] got;
        for (int i = 0; i < vq.size(); i++) begin
            probe(vq[i].x, vq[i].y, vq[i].b, got);
            check($sformatf("%s[%0d](%0d,%0d)", tag, i, vq[i].x, vq[i].y),
                  32'(got), 32'({vq[i].hit, vq[i].rgb}));
        end
        vq.delete();
    endtask

    task automatic frame_start();
        @(negedge vga_clk); drive(10'd0, 10'd0, 1'b1);
        @(negedge vga_clk); idle();
    endtask

    task automatic write_pos(input int x, input int y, input logic at_fs);
        @(negedge vga_clk);
        pos_x = 10'(x); pos_y = 10'(y); pos_wr = 1'b1;
        if (at_fs) drive(10'd0, 10'd0, 1'b1);
        else idle();
        @(negedge vga_clk); pos_wr = 1'b0; idle();
    endtask

    task automatic fill_rom(input logic [IDX_W-1:0] v);
        for (int a = 0; a < (1 << ADDR_W); a++) rom_mem[a] = v;
    endtask

    task automatic check_addr(input string name, input int x, input int y, input int exp);
        @(negedge vga_clk); drive(10'(x), 10'(y), 1'b1);
        @(negedge vga_clk);
        check(name, 32'(rom_addr), 32'(exp));
        idle();
    endtask

    initial begin
        logic [12:0] got;
        reset = 1'b1; pos_wr = 1'b0; anim_en = 1'b0; pos_x = '0; pos_y = '0;
`ifdef SPRITE_FLIP_EN
        flip_x = 1'b0;
`endif
        idle();
        fill_rom(4'd5);
        repeat (3) @(negedge vga_clk);
        check("reset_rgb_hit", 32'({sprite_hit, red, green, blue}), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;

        // Solid sprite at (100,50): 44x88 on screen.
        write_pos(100, 50, 1'b0);
        frame_start();
        vq.push_back(mk(100, 50, 1, 12'h5AF, 1));
        vq.push_back(mk(143, 50, 1, 12'h5AF, 1));
        vq.push_back(mk(144, 50, 1, 12'h029, 0));
        vq.push_back(mk(99, 50, 1, 12'h329, 0));
        vq.push_back(mk(100, 137, 1, 12'h5AF, 1));
        vq.push_back(mk(100, 138, 1, 12'h4A9, 0));
        vq.push_back(mk(120, 49, 1, 12'h819, 0));
        vq.push_back(mk(120, 100, 0, 12'h000, 0));
        run_vecs("solid");

        // Exactly three cycles: one cycle early still shows the idle (blanked) pixel.
        @(negedge vga_clk); idle();
        @(negedge vga_clk); drive(10'd100, 10'd50, 1'b1);
        @(negedge vga_clk); idle();
        @(negedge vga_clk);
        check("latency_early", 32'({sprite_hit, red, green, blue}), 32'd0);
        @(negedge vga_clk);
        check("latency_exact", 32'({sprite_hit, red, green, blue}), 32'h15AF);

        // Transparent texel (0,0), everything else index 3.
        fill_rom(4'd3);
        rom_mem[0] = 4'd0;
        vq.push_back(mk(100, 50, 1, 12'h429, 0));
        vq.push_back(mk(103, 53, 1, 12'h759, 0));
        vq.push_back(mk(104, 50, 1, 12'h3C9, 1));
        vq.push_back(mk(100, 54, 1, 12'h3C9, 1));
        run_vecs("transp");

        check_addr("addr_f0", 120, 70, 5 * SPR_W + 5);

        // Mid-frame move waits for the next frame start.
        write_pos(200, 50, 1'b0);
        vq.push_back(mk(110, 60, 1, 12'h3C9, 1));
        vq.push_back(mk(210, 60, 1, 12'h2C9, 0));
        run_vecs("dbuf_old");
        frame_start();
        vq.push_back(mk(210, 60, 1, 12'h3C9, 1));
        vq.push_back(mk(110, 60, 1, 12'hEC9, 0));
        run_vecs("dbuf_new");

        // Write coinciding with frame start lands one frame later.
        write_pos(300, 50, 1'b1);
        vq.push_back(mk(210, 60, 1, 12'h3C9, 1));
        vq.push_back(mk(310, 60, 1, 12'h6C9, 0));
        run_vecs("dbuf_fs_hold");
        frame_start();
        vq.push_back(mk(310, 60, 1, 12'h3C9, 1));
        vq.push_back(mk(210, 60, 1, 12'h2C9, 0));
        run_vecs("dbuf_fs_apply");

        write_pos(400, 50, 1'b0);
        write_pos(100, 50, 1'b0);
        frame_start();
        vq.push_back(mk(110, 60, 1, 12'h3C9, 1));
        vq.push_back(mk(410, 60, 1, 12'hAC9, 0));
        run_vecs("last_wins");

        // Animation: frame f stored as index 6+f.
        for (int f = 0; f < N_FRAMES; f++)
            for (int a = 0; a < FRAME_SZ; a++) rom_mem[f * FRAME_SZ + a] = 4'(6 + f);
        anim_en = 1'b1;
        for (int i = 0; i < 7; i++) frame_start();
        probe(10'd120, 10'd70, 1'b1, got);
        check("anim_7", 32'(got), 32'h169C);
        frame_start();
        probe(10'd120, 10'd70, 1'b1, got);
        check("anim_8", 32'(got), 32'h178D);
        check_addr("addr_f1", 120, 70, FRAME_SZ + 5 * SPR_W + 5);
        for (int i = 0; i < 16; i++) frame_start();
        probe(10'd120, 10'd70, 1'b1, got);
        check("anim_24", 32'(got), 32'h1963);
        for (int i = 0; i < 7; i++) frame_start();
        probe(10'd120, 10'd70, 1'b1, got);
        check("anim_31", 32'(got), 32'h1963);
        frame_start();
        probe(10'd120, 10'd70, 1'b1, got);
        check("anim_32_wrap", 32'(got), 32'h169C);
        anim_en = 1'b0;
        for (int i = 0; i < 8; i++) frame_start();
        probe(10'd120, 10'd70, 1'b1, got);
        check("anim_hold", 32'(got), 32'h169C);

        // Bottom-right clipping.
        fill_rom(4'd5);
        write_pos(620, 460, 1'b0);
        frame_start();
        vq.push_back(mk(620, 460, 1, 12'h5AF, 1));
        vq.push_back(mk(639, 479, 1, 12'h5AF, 1));
        vq.push_back(mk(619, 460, 1, 12'hBC9, 0));
        vq.push_back(mk(10, 460, 1, 12'hAC9, 0));
        vq.push_back(mk(620, 10, 1, 12'hCA9, 0));
        vq.push_back(mk(10, 10, 1, 12'hAA9, 0));
        vq.push_back(mk(630, 470, 0, 12'h000, 0));
        run_vecs("clip");

        // Reset in mid-stream clears pipeline, position and pending write.
        write_pos(300, 300, 1'b0);
        @(negedge vga_clk); drive(10'd630, 10'd470, 1'b1);
        @(negedge vga_clk); idle(); reset = 1'b1;
        @(negedge vga_clk);
        @(negedge vga_clk);
        check("midrst_out", 32'({sprite_hit, red, green, blue}), 32'd0);
        check("midrst_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        frame_start();
        vq.push_back(mk(5, 5, 1, 12'h5AF, 1));
        vq.push_back(mk(305, 305, 1, 12'h119, 0));
        run_vecs("post_rst");

`ifdef SPRITE_FLIP_EN
        fill_rom(4'd2);
        for (int r = 0; r < SPR_H; r++) rom_mem[r * SPR_W] = 4'd1;
        flip_x = 1'b1;
        write_pos(100, 50, 1'b0);
        flip_x = 1'b0;
        frame_start();
        vq.push_back(mk(140, 60, 1, 12'h1EB, 1));
        vq.push_back(mk(143, 60, 1, 12'h1EB, 1));
        vq.push_back(mk(139, 60, 1, 12'h2D8, 1));
        vq.push_back(mk(100, 60, 1, 12'h2D8, 1));
        run_vecs("flip");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
